sqrt_dispatch: RTL and testbench

SQRT_DISPATCH -- requirements
Module: sqrt_dispatch

---
 rtl/sqrt_dispatch.sv | 190 +++++++++++++++++++
 tb/tb_sqrt_dispatch.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_dispatch.sv
// Dispatcher that feeds a multi-cycle integer square-root core from an operand FIFO
// and collects its results, in order, into a result FIFO, with a watchdog on the core handshake.
module sqrt_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [7:0]               op_in,
  input  logic                     op_valid_in,
  output logic                     op_ready_out,
  output logic [3:0]               res_out,
  output logic                     res_valid_out,
  input  logic                     res_ready_in,
  output logic [7:0]               sqrt_a_out,
  output logic                     sqrt_start_out,
  input  logic                     sqrt_busy_in,
  input  logic [3:0]               sqrt_y_in,
  output logic                     busy_out,
  output logic                     err_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [7:0]      r_op_mem [DEPTH];
  logic [AW-1:0]   r_op_wr;
  logic [AW-1:0]   r_op_rd;
  logic [CW-1:0]   r_op_cnt;

  logic [3:0]      r_res_mem [DEPTH];
  logic [AW-1:0]   r_res_wr;
  logic [AW-1:0]   r_res_rd;
  logic [CW-1:0]   r_res_cnt;

  logic [7:0]      r_a;
  logic            r_err;
  logic [TW-1:0]   r_tmo;

  logic            w_op_push;
  logic            w_op_pop;
  logic            w_res_push;
  logic            w_res_pop;
  logic            w_issue_ok;
  logic            w_tmo_hit;
  logic            w_set_err;

  // Ready depends only on registered occupancy, so the dequeue side never reaches it.
  assign op_ready_out  = (r_op_cnt != DEPTH_C);
  assign w_op_push     = op_valid_in && op_ready_out;

  assign res_valid_out = (r_res_cnt != '0);
  assign res_out       = res_valid_out ? r_res_mem[r_res_rd] : 4'd0;
  assign w_res_pop     = res_valid_out && res_ready_in;

  // Issue only when a result slot is guaranteed, so the completion push can never stall.
  assign w_issue_ok    = (r_op_cnt != '0) && !sqrt_busy_in && (r_res_cnt < DEPTH_C);
  assign w_tmo_hit     = (r_tmo == TMO_LAST);

  assign sqrt_a_out     = r_a;
  assign sqrt_start_out = (r_state == S_ISSUE);
  assign err_out        = r_err;
  assign count_out      = r_res_cnt;
  assign busy_out       = (r_op_cnt != '0) || (r_res_cnt != '0) || (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_op_pop    = 1'b0;
    w_res_push  = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue_ok) begin
          w_state_nxt = S_ISSUE;
          w_op_pop    = 1'b1;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (sqrt_busy_in) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
          w_set_err   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!sqrt_busy_in) begin
          w_state_nxt = S_IDLE;
          w_res_push  = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
          w_set_err   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_a     <= 8'd0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_op_pop) begin
        r_a <= r_op_mem[r_op_rd];
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      // Any state change restarts the watchdog, so it times each wait state separately.
      if (w_state_nxt != r_state) begin
        r_tmo <= '0;
      end else if ((r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE)) begin
        r_tmo <= r_tmo + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_op_push) begin
      r_op_mem[r_op_wr] <= op_in;
    end
    if (w_res_push) begin
      r_res_mem[r_res_wr] <= sqrt_y_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_op_wr  <= '0;
      r_op_rd  <= '0;
      r_op_cnt <= '0;
    end else begin
      if (w_op_push) begin
        r_op_wr <= r_op_wr + AW'(1);
      end
      if (w_op_pop) begin
        r_op_rd <= r_op_rd + AW'(1);
      end
      case ({w_op_push, w_op_pop})
        2'b10:   r_op_cnt <= r_op_cnt + CW'(1);
        2'b01:   r_op_cnt <= r_op_cnt - CW'(1);
        default: r_op_cnt <= r_op_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_res_wr  <= '0;
      r_res_rd  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_res_push) begin
        r_res_wr <= r_res_wr + AW'(1);
      end
      if (w_res_pop) begin
        r_res_rd <= r_res_rd + AW'(1);
      end
      case ({w_res_push, w_res_pop})
        2'b10:   r_res_cnt <= r_res_cnt + CW'(1);
        2'b01:   r_res_cnt <= r_res_cnt - CW'(1);
        default: r_res_cnt <= r_res_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_dispatch.sv
// Bench for sqrt_dispatch: behavioural 5-cycle sqrt core, directed scenarios plus a
// randomized stream checked against an arithmetic square-root reference.
module tb_sqrt_dispatch;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    op_in = 8'd0;
  logic          op_valid_in = 1'b0;
  logic          op_ready_out;
  logic [3:0]    res_out;
  logic          res_valid_out;
  logic          res_ready_in = 1'b0;
  logic [7:0]    sqrt_a_out;
  logic          sqrt_start_out;
  logic          core_busy;
  logic [3:0]    core_y;
  logic          busy_out;
  logic          err_out;
  logic [CW-1:0] count_out;

  int n_pass = 0;
  int n_total = 0;

  sqrt_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk), .rst_in(rst_n),
    .op_in(op_in), .op_valid_in(op_valid_in), .op_ready_out(op_ready_out),
    .res_out(res_out), .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .sqrt_a_out(sqrt_a_out), .sqrt_start_out(sqrt_start_out),
    .sqrt_busy_in(core_busy), .sqrt_y_in(core_y),
    .busy_out(busy_out), .err_out(err_out), .count_out(count_out)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] isqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return 4'(r);
  endfunction

  // Behavioural core: busy for 5 cycles after a start, result valid once busy drops.
  logic       core_dead = 1'b0;
  logic       core_fin;
  logic [7:0] core_a;
  int         core_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= 1'b0; core_cnt <= 0; core_fin <= 1'b0; core_y <= 4'd0; core_a <= 8'd0;
    end else begin
      core_fin <= 1'b0;
      if (sqrt_start_out && !core_dead) begin
        core_busy <= 1'b1; core_cnt <= 5; core_a <= sqrt_a_out; core_y <= 4'd0;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          core_busy <= 1'b0; core_fin <= 1'b1; core_y <= isqrt(int'(core_a));
        end
      end
    end
  end

  logic [3:0] popped[$];
  logic [7:0] a_log[$];
  int         n_starts = 0;
  int         n_stalls = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid_out && res_ready_in) popped.push_back(res_out);
      if (sqrt_start_out) begin
        n_starts++;
        a_log.push_back(sqrt_a_out);
      end
      if (op_valid_in && !op_ready_out) n_stalls++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    popped.delete();
    a_log.delete();
    n_starts = 0;
    n_stalls = 0;
  endtask

  // Leaves op_valid_in high so consecutive calls stream back-to-back.
  task automatic push_op(input logic [7:0] v);
    int guard = 0;
    op_in = v;
    op_valid_in = 1'b1;
    while (!op_ready_out && guard < 300) begin
      tick();
      guard++;
    end
    tick();
  endtask

  task automatic wait_pops(input int k, output bit ok);
    for (int i = 0; i < 600 && popped.size() < k; i++) tick();
    ok = (popped.size() >= k);
  endtask

  function automatic logic [3:0] pop_at(input int i);
    if (i < popped.size()) return popped[i];
    return 4'bxxxx;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    n_total++; if (busy_out !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy_out); else n_pass++;
    n_total++; if (count_out !== '0) $display("FAIL reset_count: got %0d want 0", count_out); else n_pass++;
    n_total++; if (res_valid_out !== 1'b0) $display("FAIL reset_res_valid: got %0b want 0", res_valid_out); else n_pass++;
    n_total++; if (res_out !== 4'd0) $display("FAIL reset_res_out: got %0d want 0", res_out); else n_pass++;
    n_total++; if (err_out !== 1'b0) $display("FAIL reset_err: got %0b want 0", err_out); else n_pass++;
    n_total++; if (sqrt_start_out !== 1'b0) $display("FAIL reset_start: got %0b want 0", sqrt_start_out); else n_pass++;
    n_total++; if (sqrt_a_out !== 8'd0) $display("FAIL reset_a: got %0d want 0", sqrt_a_out); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (op_ready_out !== 1'b1) $display("FAIL reset_op_ready: got %0b want 1", op_ready_out); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    res_ready_in = 1'b1;
    push_op(8'd144);
    op_valid_in = 1'b0;
    wait_pops(1, ok);
    repeat (10) tick();
    n_total++; if (!ok) $display("FAIL single_timeout: got %0d results want 1", popped.size()); else n_pass++;
    n_total++; if (n_starts !== 1) $display("FAIL single_starts: got %0d want 1", n_starts); else n_pass++;
    n_total++; if (a_log.size() < 1 || a_log[0] !== 8'd144) $display("FAIL single_a: got %0d want 144", (a_log.size() > 0) ? a_log[0] : 8'd0); else n_pass++;
    n_total++; if (pop_at(0) !== 4'd12) $display("FAIL single_res: got %0d want 12", pop_at(0)); else n_pass++;
    n_total++; if (popped.size() !== 1) $display("FAIL single_count: got %0d results want 1", popped.size()); else n_pass++;
  endtask

  task automatic test_burst();
    bit ok;
    logic [7:0] ops [4];
    logic [3:0] exp [4];
    ops = '{8'd0, 8'd1, 8'd255, 8'd200};
    exp = '{4'd0, 4'd1, 4'd15, 4'd14};
    clear_logs();
    res_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) push_op(ops[i]);
    op_valid_in = 1'b0;
    wait_pops(4, ok);
    repeat (10) tick();
    n_total++; if (!ok) $display("FAIL burst_timeout: got %0d results want 4", popped.size()); else n_pass++;
    n_total++; if (n_stalls !== 0) $display("FAIL burst_ready: got %0d stalls want 0", n_stalls); else n_pass++;
    n_total++; if (n_starts !== 4) $display("FAIL burst_starts: got %0d want 4", n_starts); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (pop_at(i) !== exp[i]) $display("FAIL burst_res%0d: got %0d want %0d", i, pop_at(i), exp[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int starts_before;
    logic [7:0] ops [6];
    clear_logs();
    res_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) ops[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) push_op(ops[i]);
    op_valid_in = 1'b0;
    for (int i = 0; i < 200 && count_out != CW'(4); i++) tick();
    repeat (5) tick();
    starts_before = n_starts;
    repeat (20) tick();
    n_total++; if (count_out !== CW'(4)) $display("FAIL bp_count: got %0d want 4", count_out); else n_pass++;
    n_total++; if (n_starts !== 4) $display("FAIL bp_starts: got %0d want 4", n_starts); else n_pass++;
    n_total++; if (n_starts !== starts_before) $display("FAIL bp_start_when_full: got %0d want %0d", n_starts, starts_before); else n_pass++;
    n_total++; if (n_stalls == 0) $display("FAIL bp_op_ready_fell: got %0d stall cycles want >0", n_stalls); else n_pass++;
    n_total++; if (popped.size() !== 0) $display("FAIL bp_no_pop: got %0d want 0", popped.size()); else n_pass++;
    res_ready_in = 1'b1;
    wait_pops(6, ok);
    n_total++; if (!ok) $display("FAIL bp_drain_timeout: got %0d results want 6", popped.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (pop_at(i) !== isqrt(int'(ops[i]))) $display("FAIL bp_res%0d: got %0d want %0d", i, pop_at(i), isqrt(int'(ops[i]))); else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int guard;
    logic [7:0] ops [3];
    clear_logs();
    repeat (5) tick();
    res_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) ops[i] = 8'($urandom_range(0, 255));
    push_op(ops[0]);
    push_op(ops[1]);
    op_valid_in = 1'b0;
    for (int i = 0; i < 200 && count_out != CW'(2); i++) tick();
    n_total++; if (count_out !== CW'(2)) $display("FAIL sim_pre_count: got %0d want 2", count_out); else n_pass++;
    push_op(ops[2]);
    op_valid_in = 1'b0;
    guard = 0;
    while (!core_fin && guard < 100) begin
      tick();
      guard++;
    end
    res_ready_in = 1'b1;
    tick();
    res_ready_in = 1'b0;
    n_total++; if (count_out !== CW'(2)) $display("FAIL sim_count: got %0d want 2", count_out); else n_pass++;
    n_total++; if (popped.size() !== 1) $display("FAIL sim_one_pop: got %0d want 1", popped.size()); else n_pass++;
    res_ready_in = 1'b1;
    wait_pops(3, ok);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (pop_at(i) !== isqrt(int'(ops[i]))) $display("FAIL sim_res%0d: got %0d want %0d", i, pop_at(i), isqrt(int'(ops[i]))); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int guard;
    logic [7:0] v;
    clear_logs();
    res_ready_in = 1'b1;
    core_dead = 1'b1;
    push_op(8'd99);
    op_valid_in = 1'b0;
    guard = 0;
    while (!sqrt_start_out && guard < 50) begin
      tick();
      guard++;
    end
    n_total++; if (sqrt_start_out !== 1'b1) $display("FAIL tmo_issue: got %0b want 1", sqrt_start_out); else n_pass++;
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      tick();
      if (k == TIMEOUT) begin
        n_total++; if (err_out !== 1'b0) $display("FAIL tmo_err_early: got %0b want 0", err_out); else n_pass++;
      end
    end
    n_total++; if (err_out !== 1'b1) $display("FAIL tmo_err: got %0b want 1", err_out); else n_pass++;
    n_total++; if (busy_out !== 1'b0) $display("FAIL tmo_idle: got busy %0b want 0", busy_out); else n_pass++;
    n_total++; if (count_out !== '0) $display("FAIL tmo_no_result: got %0d want 0", count_out); else n_pass++;
    core_dead = 1'b0;
    v = 8'($urandom_range(0, 255));
    push_op(v);
    op_valid_in = 1'b0;
    wait_pops(1, ok);
    repeat (3) tick();
    n_total++; if (pop_at(0) !== isqrt(int'(v))) $display("FAIL tmo_next_res: got %0d want %0d", pop_at(0), isqrt(int'(v))); else n_pass++;
    n_total++; if (popped.size() !== 1) $display("FAIL tmo_pop_count: got %0d want 1", popped.size()); else n_pass++;
    n_total++; if (err_out !== 1'b1) $display("FAIL tmo_sticky: got %0b want 1", err_out); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] ops [16];
    clear_logs();
    for (int i = 0; i < 16; i++) ops[i] = 8'($urandom_range(0, 255));
    fork
      begin
        for (int i = 0; i < 16; i++) push_op(ops[i]);
        op_valid_in = 1'b0;
      end
      begin
        for (int j = 0; j < 120; j++) begin
          res_ready_in = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    res_ready_in = 1'b1;
    wait_pops(16, ok);
    n_total++; if (!ok) $display("FAIL rand_timeout: got %0d results want 16", popped.size()); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++; if (pop_at(i) !== isqrt(int'(ops[i]))) $display("FAIL rand_res%0d: got %0d want %0d", i, pop_at(i), isqrt(int'(ops[i]))); else n_pass++;
    end
  endtask

  task automatic test_reset_midop();
    int guard;
    clear_logs();
    res_ready_in = 1'b0;
    push_op(8'd50);
    push_op(8'd81);
    op_valid_in = 1'b0;
    guard = 0;
    while (count_out != CW'(1) && guard < 100) begin tick(); guard++; end
    guard = 0;
    while (!core_busy && guard < 20) begin tick(); guard++; end
    repeat (2) tick();
    n_total++; if (busy_out !== 1'b1) $display("FAIL rst_pre_busy: got %0b want 1", busy_out); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (count_out !== '0) $display("FAIL rst_count: got %0d want 0", count_out); else n_pass++;
    n_total++; if (res_valid_out !== 1'b0) $display("FAIL rst_res_valid: got %0b want 0", res_valid_out); else n_pass++;
    n_total++; if (busy_out !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy_out); else n_pass++;
    n_total++; if (err_out !== 1'b0) $display("FAIL rst_err: got %0b want 0", err_out); else n_pass++;
    n_total++; if (sqrt_a_out !== 8'd0) $display("FAIL rst_a: got %0d want 0", sqrt_a_out); else n_pass++;
    n_total++; if (res_out !== 4'd0) $display("FAIL rst_res_out: got %0d want 0", res_out); else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    clear_logs();
    res_ready_in = 1'b1;
    repeat (40) tick();
    n_total++; if (popped.size() !== 0) $display("FAIL rst_no_result: got %0d want 0", popped.size()); else n_pass++;
    n_total++; if (n_starts !== 0) $display("FAIL rst_no_start: got %0d want 0", n_starts); else n_pass++;
    n_total++; if (op_ready_out !== 1'b1) $display("FAIL rst_op_ready: got %0b want 1", op_ready_out); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_simultaneous();
    test_timeout();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
